// File: rtl/bcp_sched_pkg.sv
// Shared SAT types: signed literal, clause length and the BCP scheduler state set.
// Literal 0 is reserved as "no literal" and is never queued.
package bcp_sched_pkg;

    localparam int LIT_W      = 16;
    localparam int CLA_LENGTH = 8;

    typedef logic signed [LIT_W-1:0] lit_t;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_DEC,
        BCAST,
        WAIT,
        CONFL
    } bcp_sched_state_t;

    function automatic logic lit_is_zero(input lit_t l);
        return (l == '0);
    endfunction

endpackage

// File: rtl/bcp_sched_if.sv
// Scheduler <-> PE array / unit-clause queue / host bundle.
// master = scheduler side, slave = environment side.
interface bcp_sched_if
    import bcp_sched_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int STAT_W = 16
);
    logic                    start;
    lit_t                    dec_lit;
    logic                    clear;
    logic [NUM_PE-1:0]       pe_imply;
    lit_t [NUM_PE-1:0]       pe_imply_idx;
    logic [NUM_PE-1:0]       pe_conflict;
    logic [NUM_PE-1:0]       pe_busy;
    logic [NUM_PE-1:0]       pe_grant;
    logic                    bcast_valid;
    lit_t                    bcast_lit;
    logic                    ucq_push;
    lit_t                    ucq_wdata;
    logic                    ucq_full;
    logic                    ucq_pop;
    lit_t                    ucq_rdata;
    logic                    ucq_empty;
    logic                    busy;
    logic                    done;
    logic                    conflict;
    logic [STAT_W-1:0]       stat_rounds;
    logic [STAT_W-1:0]       stat_imps;

    modport master (
        input  start, dec_lit, clear, pe_imply, pe_imply_idx, pe_conflict, pe_busy,
               ucq_full, ucq_rdata, ucq_empty,
        output pe_grant, bcast_valid, bcast_lit, ucq_push, ucq_wdata, ucq_pop,
               busy, done, conflict, stat_rounds, stat_imps
    );

    modport slave (
        output start, dec_lit, clear, pe_imply, pe_imply_idx, pe_conflict, pe_busy,
               ucq_full, ucq_rdata, ucq_empty,
        input  pe_grant, bcast_valid, bcast_lit, ucq_push, ucq_wdata, ucq_pop,
               busy, done, conflict, stat_rounds, stat_imps
    );

endinterface

// File: rtl/bcp_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant among N requests when enabled;
// priority pointer moves to the slot after the winner only on a grant.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);
    localparam logic [PW:0] N_V = (PW+1)'(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic           hit;
    logic [PW:0]    sum;

    // Rotate so bit 0 is the highest-priority slot.
    assign req_dbl = {req_i, req_i};
    assign rot     = N'(req_dbl >> ptr_q);

    always_comb begin
        off = '0;
        hit = 1'b0;
        for (int k = N-1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PW'(k);
                hit = 1'b1;
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= N_V) begin
            sum = sum - N_V;
        end
    end

    assign vld_o = en_i & hit;
    assign idx_o = sum[PW-1:0];
    assign ptr_d = (sum == N_V - (PW+1)'(1)) ? '0 : sum[PW-1:0] + PW'(1);

    always_comb begin
        gnt_o = '0;
        if (vld_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (vld_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bcp_sched.sv
// BCP scheduler: pushes a decision, broadcasts queued unit literals, collects PE implications.
// Grant-to-push is zero-cycle; ucq_full stalls pushes/grants. Stats behind BCP_SCHED_STATS_EN.
module bcp_sched
    import bcp_sched_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int STAT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    bcp_sched_if.master  bus
);
    localparam int PW = $clog2(NUM_PE);

    bcp_sched_state_t state_q, state_d;
    lit_t             dec_q, dec_d;

    logic [NUM_PE-1:0] grant;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic              arb_en;
    logic              any_confl;
    logic              settled;
    lit_t              gnt_lit;
    logic              imp_push;

    assign any_confl = |bus.pe_conflict;
    assign settled   = (bus.pe_busy == '0) && (bus.pe_imply == '0);
    // Conflict beats any grant raised in the same cycle.
    assign arb_en    = (state_q == WAIT) && !any_confl && !bus.ucq_full;
    assign gnt_lit   = bus.pe_imply_idx[gnt_idx];

    rr_arbiter #(.N(NUM_PE)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (bus.pe_imply),
        .en_i  (arb_en),
        .gnt_o (grant),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    always_comb begin
        state_d         = state_q;
        dec_d           = dec_q;
        bus.ucq_push    = 1'b0;
        bus.ucq_wdata   = '0;
        bus.ucq_pop     = 1'b0;
        bus.bcast_valid = 1'b0;
        bus.bcast_lit   = '0;
        bus.done        = 1'b0;
        imp_push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dec_d   = bus.dec_lit;
                    state_d = PUSH_DEC;
                end
            end
            PUSH_DEC: begin
                if (!bus.ucq_full) begin
                    bus.ucq_push  = !lit_is_zero(dec_q);
                    bus.ucq_wdata = lit_is_zero(dec_q) ? '0 : dec_q;
                    state_d       = BCAST;
                end
            end
            BCAST: begin
                if (any_confl) begin
                    state_d = CONFL;
                end else if (!bus.ucq_empty) begin
                    bus.ucq_pop     = 1'b1;
                    bus.bcast_valid = 1'b1;
                    bus.bcast_lit   = bus.ucq_rdata;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (any_confl) begin
                    state_d = CONFL;
                end else begin
                    // A zero literal is still granted so the PE retires it.
                    if (gnt_vld && !lit_is_zero(gnt_lit)) begin
                        bus.ucq_push  = 1'b1;
                        bus.ucq_wdata = gnt_lit;
                        imp_push      = 1'b1;
                    end
                    if (settled) begin
                        if (!bus.ucq_empty) begin
                            state_d = BCAST;
                        end else begin
                            bus.done = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end
            end
            CONFL: begin
                if (bus.clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
        end
    end

    assign bus.pe_grant = grant;
    assign bus.busy     = (state_q != IDLE);
    assign bus.conflict = (state_q == CONFL);

`ifdef BCP_SCHED_STATS_EN
    logic [STAT_W-1:0] rounds_q, imps_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rounds_q <= '0;
            imps_q   <= '0;
        end else begin
            if (bus.bcast_valid && (rounds_q != '1)) begin
                rounds_q <= rounds_q + STAT_W'(1);
            end
            if (imp_push && (imps_q != '1)) begin
                imps_q <= imps_q + STAT_W'(1);
            end
        end
    end

    assign bus.stat_rounds = rounds_q;
    assign bus.stat_imps   = imps_q;
`else
    assign bus.stat_rounds = {STAT_W{1'b0}};
    assign bus.stat_imps   = {STAT_W{1'b0}};
`endif

endmodule

// File: doc/bcp_sched.md
BCP_SCHED -- requirements
Module: bcp_sched

Interface
REQ-001 The block SHALL have parameter NUM_PE, default 4, giving the number of bcp_pe instances scheduled (2..16).
REQ-002 The block SHALL have parameter STAT_W, default 16, giving the width of the statistics counters.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to propagate decision literal dec_lit.
REQ-006 dec_lit  in  lit_t  new decision literal, sampled when start is accepted.
REQ-007 clear  in  1  host acknowledge of a conflict; returns the block to IDLE.
REQ-008 pe_imply  in  NUM_PE  per-PE implication valid, held by the PE until granted.
REQ-009 pe_imply_idx  in  NUM_PE x lit_t  per-PE implied literal.
REQ-010 pe_conflict  in  NUM_PE  per-PE conflict flag.
REQ-011 pe_busy  in  NUM_PE  per-PE "clause queue not yet drained for current literal".
REQ-012 pe_grant  out  NUM_PE  one-hot grant; the granted PE drops its implication next cycle.
REQ-013 bcast_valid / bcast_lit  out  1 / lit_t  one-cycle broadcast of the active unit literal to all PEs.
REQ-014 ucq_push / ucq_wdata / ucq_full  out / out / in  1 / lit_t / 1  unit-clause queue write port.
REQ-015 ucq_pop / ucq_rdata / ucq_empty  out / in / in  1 / lit_t / 1  unit-clause queue read port; rdata valid whenever !ucq_empty.
REQ-016 busy / done / conflict  out  1 each  scheduler active / one-cycle propagation-complete pulse / sticky conflict.
REQ-017 stat_rounds / stat_imps  out  STAT_W each  broadcast and implication counts (see Configuration).

Function
REQ-018 States SHALL be IDLE, PUSH_DEC, BCAST, WAIT, CONFL; busy = (state != IDLE).
REQ-019 IDLE: start accepted only in IDLE and SHALL latch dec_lit and go to PUSH_DEC; start in any other state SHALL be ignored.
REQ-020 PUSH_DEC: ucq_push=1, ucq_wdata=latched literal when !ucq_full, then go to BCAST; while ucq_full stall.
REQ-021 BCAST: when !ucq_empty assert ucq_pop, bcast_valid=1, bcast_lit=ucq_rdata for exactly one cycle, go to WAIT.
REQ-022 WAIT: each cycle at most one pending pe_imply SHALL be granted, round-robin starting after the last granted PE, only when !ucq_full; the grant cycle SHALL assert ucq_push with that PE's literal (zero-cycle grant-to-push).
REQ-023 Round-robin pointer SHALL advance only on a grant; with ucq_full no grant and no push.
REQ-024 WAIT exit when pe_busy==0 and pe_imply==0: go to BCAST if !ucq_empty, else assert done for one cycle and go to IDLE.
REQ-025 Any pe_conflict bit in BCAST or WAIT SHALL move to CONFL next cycle; conflict has priority: no grant or push in that cycle.
REQ-026 CONFL: conflict=1, no grants, no pushes, no pops; clear SHALL return to IDLE and drop conflict next cycle.
REQ-027 pe_conflict in IDLE or PUSH_DEC SHALL be ignored.
REQ-028 Literal value zero SHALL never be pushed; a granted implication with literal 0 is consumed (granted) but not pushed.

Reset
REQ-029 On rst_n=0, state SHALL be IDLE, all outputs 0, RR pointer 0, latched literal 0, counters 0, taking effect at the next edge even mid-propagation.

Configuration
REQ-030 With BCP_SCHED_STATS_EN defined, stat_rounds SHALL increment on each bcast_valid and stat_imps on each implication push, saturating at all-ones, cleared only by reset.
REQ-031 Without BCP_SCHED_STATS_EN, counters SHALL not be synthesised and stat_rounds/stat_imps SHALL be tied to 0.

Structure
REQ-032 lit_t, CLA_LENGTH and the state enum bcp_sched_state_t SHALL live in the shared SAT package.
REQ-033 Round-robin arbitration SHALL be a sub-module rr_arbiter (NUM_PE requests, enable, one-hot grant, pointer update on grant).

Verification
REQ-034 start, dec_lit=5, PEs never busy/imply -> ucq_push(5), bcast_lit=5, done pulse 3 cycles after start (PUSH_DEC->BCAST->WAIT).
REQ-035 After broadcast of 5, PE0 and PE2 imply -3 and 7 same cycle -> grants PE0 then PE2 on consecutive cycles, pushes -3 then 7, next broadcasts -3 then 7.
REQ-036 ucq_full held 4 cycles while PE1 implies 9 -> no grant, no push; grant and push of 9 on first cycle after full drops.
REQ-037 PE3 conflict in same cycle as PE1 imply 4 -> no push of 4, conflict=1 next cycle, held until clear, IDLE one cycle after clear.
REQ-038 rst_n low during WAIT with pending implications -> IDLE, all outputs 0 next cycle; with BCP_SCHED_STATS_EN, stat_rounds saturates at 16'hFFFF after 65536+ broadcasts.
